// File: rtl/mips_single_cycle.sv
// mips_single_cycle: single-cycle MIPS-Lite CPU with internal memories, register file and HI/LO
module instr_mem #(
  parameter int BYTES = 128
) (
  input  logic [31:0] addr,
  output logic [31:0] instr
);
  localparam int AW = $clog2(BYTES);
  logic [7:0] mem_array [0:BYTES-1];
  logic [AW-3:0] w;
  logic unused_addr;
  assign w = addr[AW-1:2];
  assign unused_addr = ^{addr[31:AW], addr[1:0]};
  assign instr = {mem_array[{w, 2'd3}], mem_array[{w, 2'd2}], mem_array[{w, 2'd1}], mem_array[{w, 2'd0}]};
endmodule

module dat_mem #(
  parameter int BYTES = 128
) (
  input  logic        clk,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd
);
  localparam int AW = $clog2(BYTES);
  logic [7:0] mem_array [0:BYTES-1];
  logic [AW-3:0] w;
  logic unused_addr;
  assign w = addr[AW-1:2];
  assign unused_addr = ^{addr[31:AW], addr[1:0]};
  assign rd = {mem_array[{w, 2'd3}], mem_array[{w, 2'd2}], mem_array[{w, 2'd1}], mem_array[{w, 2'd0}]};
  // little-endian word store; memory contents survive reset
  always_ff @(posedge clk)
    if (we) begin
      mem_array[{w, 2'd0}] <= wd[7:0];
      mem_array[{w, 2'd1}] <= wd[15:8];
      mem_array[{w, 2'd2}] <= wd[23:16];
      mem_array[{w, 2'd3}] <= wd[31:24];
    end
endmodule

module reg_file (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] file_array [0:31];
  assign rd1 = ra1 == 5'd0 ? 32'd0 : file_array[ra1];
  assign rd2 = ra2 == 5'd0 ? 32'd0 : file_array[ra2];
  // synchronous write, $0 stays hardwired to zero
  always_ff @(posedge clk)
    if (we && wa != 5'd0) file_array[wa] <= wd;
endmodule

module mips_single_cycle #(
  parameter int INSTR_BYTES = 128,
  parameter int DATA_BYTES  = 128
) (
  input logic clk,
  input logic rst
);
  logic [31:0] pc, instr, hi, lo, rs_val, rt_val, imm_ext, alu_res, mem_rd, rfile_wd, pc_plus4, pc_next;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd, shamt, wa;
  logic is_r, is_addiu, is_lw, is_sw, is_beq, is_bne, is_j, is_multu, is_mfhi, is_mflo, r_wr, rf_we;
  assign opcode = instr[31:26];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign rd = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];
  assign imm_ext = {{16{instr[15]}}, instr[15:0]};
  assign is_r = opcode == 6'd0;
  assign is_addiu = opcode == 6'd9;
  assign is_lw = opcode == 6'd35;
  assign is_sw = opcode == 6'd43;
  assign is_beq = opcode == 6'd4;
  assign is_bne = opcode == 6'd5;
  assign is_j = opcode == 6'd2;
  assign is_multu = is_r && funct == 6'd25;
  assign is_mfhi = is_r && funct == 6'd10;
  assign is_mflo = is_r && funct == 6'd12;
  assign r_wr = is_r && (funct == 6'd32 || funct == 6'd34 || funct == 6'd36 || funct == 6'd37 ||
                         funct == 6'd0 || funct == 6'd42 || is_mfhi || is_mflo);
  assign rf_we = !rst && (r_wr || is_addiu || is_lw);
  assign wa = is_r ? rd : rt;
  instr_mem #(.BYTES(INSTR_BYTES)) InstrMem (.addr(pc), .instr(instr));
  reg_file RegFile (.clk(clk), .we(rf_we), .ra1(rs), .ra2(rt), .wa(wa), .wd(rfile_wd), .rd1(rs_val), .rd2(rt_val));
  dat_mem #(.BYTES(DATA_BYTES)) DatMem (.clk(clk), .we(!rst && is_sw), .addr(alu_res), .wd(rt_val), .rd(mem_rd));
  // ALU, write-back mux and next-PC selection
  always_comb begin
    alu_res = !is_r ? rs_val + imm_ext :
              funct == 6'd34 ? rs_val - rt_val :
              funct == 6'd36 ? rs_val & rt_val :
              funct == 6'd37 ? rs_val | rt_val :
              funct == 6'd0  ? rt_val << shamt :
              funct == 6'd42 ? {31'd0, $signed(rs_val) < $signed(rt_val)} :
              rs_val + rt_val;
    rfile_wd = is_lw ? mem_rd : is_mfhi ? hi : is_mflo ? lo : alu_res;
    pc_plus4 = pc + 32'd4;
    pc_next = (is_beq && rs_val == rt_val) || (is_bne && rs_val != rt_val) ? pc_plus4 + (imm_ext << 2) :
              is_j ? {pc_plus4[31:28], instr[25:0], 2'b00} : pc_plus4;
  end
  // PC and HI/LO state, cleared asynchronously by reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= 32'd0;
      hi <= 32'd0;
      lo <= 32'd0;
    end else begin
      pc <= pc_next;
      if (is_multu) {hi, lo} <= 64'(rs_val) * 64'(rt_val);
    end
endmodule

// File: tb/tb_mips_single_cycle.sv
// tb_mips_single_cycle: scoreboard bench for the single-cycle MIPS-Lite CPU
module tb_mips_single_cycle;
  logic clk = 0, rst = 1;
  int n_cmp = 0, n_err = 0;
  typedef struct {logic [31:0] pc; logic [31:0] wd; bit cw; string nm;} exp_t;
  exp_t q[$];

  mips_single_cycle #(.INSTR_BYTES(128), .DATA_BYTES(128)) dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] r(input int s, input int t, input int d, input int sh, input int fn);
    return {6'd0, 5'(s), 5'(t), 5'(d), 5'(sh), 6'(fn)};
  endfunction
  function automatic logic [31:0] i(input int op, input int s, input int t, input int imm);
    return {6'(op), 5'(s), 5'(t), 16'(imm)};
  endfunction

  task automatic put_w(input int a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) dut.InstrMem.mem_array[a + k] = w[8*k +: 8];
  endtask
  task automatic push(input logic [31:0] p, input logic [31:0] w, input bit c, input string nm);
    exp_t e;
    e.pc = p; e.wd = w; e.cw = c; e.nm = nm;
    q.push_back(e);
  endtask
  task automatic drain;
    int k = 0;
    while (q.size() > 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (q.size() > 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    #1;
  endtask

  // monitor: every executing cycle presents pc and rfile_wd, compared against the queue
  always @(negedge clk)
    if (!rst && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.nm, "_pc"}, dut.pc, e.pc);
      if (e.cw) chk({e.nm, "_wd"}, dut.rfile_wd, e.wd);
    end

  initial begin
    for (int a = 0; a < 128; a++) dut.InstrMem.mem_array[a] = 8'd0;
    dut.RegFile.file_array[0] = 32'd0;
    dut.RegFile.file_array[1] = 32'd5;
    dut.RegFile.file_array[2] = 32'd3;
    dut.RegFile.file_array[7] = 32'hDEAD;
    put_w(0,  r(1, 2, 3, 0, 32));
    put_w(4,  r(1, 2, 3, 0, 34));
    put_w(8,  r(1, 2, 3, 0, 36));
    put_w(12, r(1, 2, 3, 0, 37));
    put_w(16, r(2, 1, 3, 0, 42));
    put_w(20, r(0, 1, 3, 2, 0));
    put_w(24, i(9, 0, 4, -1));
    put_w(28, i(9, 0, 1, -1));
    put_w(32, i(9, 0, 2, 2));
    put_w(36, r(1, 2, 0, 0, 25));
    put_w(40, r(0, 0, 5, 0, 10));
    put_w(44, r(0, 0, 6, 0, 12));
    put_w(48, i(9, 0, 0, 7));
    put_w(52, i(63, 0, 3, 5));
    put_w(56, 32'd0);
    @(negedge clk);
    chk("rst_pc", dut.pc, 32'd0);
    chk("rst_hi", dut.hi, 32'd0);
    chk("rst_lo", dut.lo, 32'd0);
    chk("rst_keeps_r7", dut.RegFile.file_array[7], 32'hDEAD);
    push(0,  32'd8, 1, "add");
    push(4,  32'd2, 1, "sub");
    push(8,  32'd1, 1, "and");
    push(12, 32'd7, 1, "or");
    push(16, 32'd1, 1, "slt");
    push(20, 32'd20, 1, "sll");
    push(24, 32'hFFFFFFFF, 1, "addiu_m1");
    push(28, 32'hFFFFFFFF, 1, "addiu_r1");
    push(32, 32'd2, 1, "addiu_r2");
    push(36, 32'd0, 0, "multu");
    push(40, 32'd1, 1, "mfhi");
    push(44, 32'hFFFFFFFE, 1, "mflo");
    push(48, 32'd7, 1, "addiu_r0");
    push(52, 32'd0, 0, "unknown_op");
    push(56, 32'd0, 1, "nop");
    @(posedge clk);
    #1 rst = 0;
    drain();
    chk("a_pc", dut.pc, 32'd60);
    chk("a_hi", dut.hi, 32'd1);
    chk("a_lo", dut.lo, 32'hFFFFFFFE);
    chk("a_r0", dut.RegFile.file_array[0], 32'd0);
    chk("a_r3", dut.RegFile.file_array[3], 32'd20);
    chk("a_r4", dut.RegFile.file_array[4], 32'hFFFFFFFF);
    chk("a_r5", dut.RegFile.file_array[5], 32'd1);
    chk("a_r6", dut.RegFile.file_array[6], 32'hFFFFFFFE);
    rst = 1;
    #1;
    chk("async_rst_pc", dut.pc, 32'd0);
    chk("async_rst_hi", dut.hi, 32'd0);
    chk("async_rst_lo", dut.lo, 32'd0);
    chk("async_rst_r7", dut.RegFile.file_array[7], 32'hDEAD);
    for (int a = 0; a < 128; a++) dut.InstrMem.mem_array[a] = 8'd0;
    dut.DatMem.mem_array[4] = 8'h78;
    dut.DatMem.mem_array[5] = 8'h56;
    dut.DatMem.mem_array[6] = 8'h34;
    dut.DatMem.mem_array[7] = 8'h12;
    for (int a = 8; a < 12; a++) dut.DatMem.mem_array[a] = 8'd0;
    dut.RegFile.file_array[1] = 32'd0;
    dut.RegFile.file_array[9] = 32'd0;
    put_w(0,  i(35, 1, 2, 4));
    put_w(4,  i(43, 1, 2, 8));
    put_w(8,  i(4, 1, 1, 2));
    put_w(12, i(9, 0, 9, 1));
    put_w(16, i(9, 0, 9, 1));
    put_w(20, i(5, 1, 1, 5));
    put_w(24, {6'd2, 26'h10});
    put_w(64, i(9, 0, 10, 32'h55));
    push(0,  32'h12345678, 1, "lw");
    push(4,  32'd0, 0, "sw");
    push(8,  32'd0, 0, "beq_taken");
    push(20, 32'd0, 0, "bne_not_taken");
    push(24, 32'd0, 0, "j");
    push(64, 32'h55, 1, "addiu_after_j");
    @(posedge clk);
    #1 rst = 0;
    drain();
    chk("b_pc", dut.pc, 32'd68);
    chk("b_r2", dut.RegFile.file_array[2], 32'h12345678);
    chk("b_r9_skipped", dut.RegFile.file_array[9], 32'd0);
    chk("b_r10", dut.RegFile.file_array[10], 32'h55);
    chk("sw_bytes", {dut.DatMem.mem_array[11], dut.DatMem.mem_array[10], dut.DatMem.mem_array[9], dut.DatMem.mem_array[8]}, 32'h12345678);
    chk("sw_byte8", {24'd0, dut.DatMem.mem_array[8]}, 32'h78);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
